// File: rtl/riscv_core_branch_predictor.sv
// rtl/riscv_core_branch_predictor.sv - bimodal BHT plus tagged BTB fetch-stage branch predictor
module riscv_core_branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 16,
    parameter int CNT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   i_branch_pred_lookup_pc,
    output logic              o_branch_pred_hit,
    output logic              o_branch_pred_taken,
    output logic [XLEN-1:0]   o_branch_pred_target,
    input  logic              i_branch_pred_upd_valid,
    input  logic [XLEN-1:0]   i_branch_pred_upd_pc,
    input  logic              i_branch_pred_upd_taken,
    input  logic [XLEN-1:0]   i_branch_pred_upd_target,
    input  logic              i_branch_pred_upd_mispredict,
    output logic [CNT_W-1:0]  o_branch_pred_mispredict_cnt
);
    localparam int TAG_HI = IDX_W + TAG_W;

    logic [1:0]       ctr_q        [ENTRIES];
    logic [ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
    logic [XLEN-1:0]  btb_target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] lidx, uidx;
    logic [TAG_W-1:0] ltag, utag;
    logic [1:0]       uctr, uctr_next;

    assign lidx = i_branch_pred_lookup_pc[IDX_W:1];
    assign ltag = i_branch_pred_lookup_pc[TAG_HI:IDX_W+1];
    assign uidx = i_branch_pred_upd_pc[IDX_W:1];
    assign utag = i_branch_pred_upd_pc[TAG_HI:IDX_W+1];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        o_branch_pred_hit    = btb_valid_q[lidx] && (btb_tag_q[lidx] == ltag);
        o_branch_pred_taken  = o_branch_pred_hit && ctr_q[lidx][1];
        o_branch_pred_target = o_branch_pred_taken ? btb_target_q[lidx] : '0;
    end

    always_comb begin
        uctr      = ctr_q[uidx];
        uctr_next = uctr;
        if (i_branch_pred_upd_taken) begin
            if (uctr != 2'b11) uctr_next = uctr + 2'b01;
        end else begin
            if (uctr != 2'b00) uctr_next = uctr - 2'b01;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_branch_pred_upd_valid && i_branch_pred_upd_mispredict && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
            btb_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_branch_pred_upd_valid) begin
                ctr_q[uidx] <= uctr_next;
                if (i_branch_pred_upd_taken) btb_valid_q[uidx] <= 1'b1;
            end
        end
    end

    // Tag/target payload is qualified by btb_valid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_branch_pred_upd_valid && i_branch_pred_upd_taken) begin
            btb_tag_q[uidx]    <= utag;
            btb_target_q[uidx] <= i_branch_pred_upd_target;
        end
    end

    assign o_branch_pred_mispredict_cnt = cnt_q;

    logic unused_pc_bits;
    generate
        if (TAG_HI + 1 < XLEN) begin : g_hi
            assign unused_pc_bits = ^{i_branch_pred_lookup_pc[0], i_branch_pred_upd_pc[0],
                                      i_branch_pred_lookup_pc[XLEN-1:TAG_HI+1],
                                      i_branch_pred_upd_pc[XLEN-1:TAG_HI+1]};
        end else begin : g_nohi
            assign unused_pc_bits = i_branch_pred_lookup_pc[0] ^ i_branch_pred_upd_pc[0];
        end
    endgenerate
endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// tb/tb_riscv_core_branch_predictor.sv - directed vector bench for riscv_core_branch_predictor
module tb_riscv_core_branch_predictor;
    localparam logic [63:0] PA = 64'h0000_0000_8000_0040;
    localparam logic [63:0] PB = 64'h0000_0000_8000_00C0;
    localparam logic [63:0] PC = 64'h0000_0000_8000_0010;
    localparam logic [63:0] T1 = 64'h0000_0000_8000_0100;
    localparam logic [63:0] T2 = 64'h0000_0000_8000_0200;
    localparam logic [63:0] TX = 64'h0000_0000_DEAD_BEE0;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] lookup_pc;
    logic        upd_valid, upd_taken, upd_mis;
    logic [63:0] upd_pc, upd_target;
    logic        hit, taken;
    logic [63:0] target;
    logic [31:0] cnt;
    logic        s_hit, s_taken;
    logic [63:0] s_target;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    riscv_core_branch_predictor dut (
        .i_clk(clk), .i_rst(rst),
        .i_branch_pred_lookup_pc(lookup_pc),
        .o_branch_pred_hit(hit), .o_branch_pred_taken(taken), .o_branch_pred_target(target),
        .i_branch_pred_upd_valid(upd_valid), .i_branch_pred_upd_pc(upd_pc),
        .i_branch_pred_upd_taken(upd_taken), .i_branch_pred_upd_target(upd_target),
        .i_branch_pred_upd_mispredict(upd_mis),
        .o_branch_pred_mispredict_cnt(cnt)
    );

    riscv_core_branch_predictor #(.CNT_W(4)) dut_small (
        .i_clk(clk), .i_rst(rst),
        .i_branch_pred_lookup_pc(lookup_pc),
        .o_branch_pred_hit(s_hit), .o_branch_pred_taken(s_taken), .o_branch_pred_target(s_target),
        .i_branch_pred_upd_valid(upd_valid), .i_branch_pred_upd_pc(upd_pc),
        .i_branch_pred_upd_taken(upd_taken), .i_branch_pred_upd_target(upd_target),
        .i_branch_pred_upd_mispredict(upd_mis),
        .o_branch_pred_mispredict_cnt(s_cnt)
    );

    typedef struct {
        logic        rst;
        logic [63:0] lpc;
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        um;
        logic        chk;
        logic        eh;
        logic        et;
        logic [63:0] etgt;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic v(input logic r, input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                     input logic ut, input logic [63:0] utgt, input logic um, input logic chk,
                     input logic eh, input logic et, input logic [63:0] etgt, input logic [31:0] ecnt);
        vec_t x;
        x.rst = r; x.lpc = lpc; x.uv = uv; x.upc = upc; x.ut = ut; x.utgt = utgt; x.um = um;
        x.chk = chk; x.eh = eh; x.et = et; x.etgt = etgt; x.ecnt = ecnt;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; lookup_pc = x.lpc; upd_valid = x.uv; upd_pc = x.upc;
        upd_taken = x.ut; upd_target = x.utgt; upd_mis = x.um;
    endtask

    task automatic idle_upd(input logic r, input logic uv, input logic um);
        rst = r; upd_valid = uv; upd_mis = um; upd_pc = PC; upd_taken = 1'b0; upd_target = TX;
    endtask

    initial begin
        rst = 1'b1; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mis = 1'b0;

        // Expectations describe the lookup seen before that row's update edge.
        v(1, PA, 0, PA, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, PA, 0, PA, 0, 0, 0, 1, 0, 0, 0, 0);
        v(0, PA, 1, PA, 1, T1, 0, 1, 0, 0, 0, 0);   // same-cycle first training
        v(0, PA, 1, PA, 0, 0, 0, 1, 1, 1, T1, 0);   // ctr 10 -> 01
        v(0, PA, 1, PA, 0, 0, 0, 1, 1, 0, 0, 0);    // 01 -> 00
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 0, 0, 0);   // 00 -> 01
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 0, 0, 0);   // 01 -> 10
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 1, T1, 0);  // 10 -> 11
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 1, T1, 0);  // 11 stays
        v(0, PA, 1, PA, 0, 0, 0, 1, 1, 1, T1, 0);   // 11 -> 10
        v(0, PA, 0, PA, 0, 0, 0, 1, 1, 1, T1, 0);   // ctr 10 still taken
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 1, T1, 0);  // back to 11
        for (int i = 0; i < 8; i++)
            v(0, PA, 1, PA, 0, 0, 0, 1, 1, (i < 2), (i < 2) ? T1 : 64'h0, 0);
        v(0, PA, 0, PA, 0, 0, 0, 1, 1, 0, 0, 0);    // 00, no wrap
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 0, 0, 0);
        v(0, PA, 1, PA, 1, T1, 0, 1, 1, 0, 0, 0);
        v(0, PA, 0, PA, 0, 0, 0, 1, 1, 1, T1, 0);
        v(0, PB, 0, PA, 0, 0, 0, 1, 0, 0, 0, 0);    // alias: same idx, other tag
        v(0, PB, 1, PB, 1, T2, 0, 1, 0, 0, 0, 0);
        v(0, PA, 0, PA, 0, 0, 0, 1, 0, 0, 0, 0);
        v(0, PB, 0, PA, 0, 0, 0, 1, 1, 1, T2, 0);
        for (int i = 0; i < 5; i++)
            v(0, PB, 1, PC, 0, 0, 1, 1, 1, 1, T2, i);
        v(0, PB, 0, PB, 0, TX, 1, 1, 1, 1, T2, 5);  // invalid update ignored
        v(0, PB, 0, PB, 1, TX, 1, 1, 1, 1, T2, 5);
        v(0, PB, 1, PB, 1, TX, 1, 1, 1, 1, T2, 5);  // reset row below wins
        vecs[$].rst = 1'b1;
        v(0, PB, 0, PB, 0, 0, 0, 1, 0, 0, 0, 0);
        v(0, PA, 1, PA, 1, T1, 0, 1, 0, 0, 0, 0);   // counter restarted at 01
        v(0, PA, 0, PA, 0, 0, 0, 1, 1, 1, T1, 0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                check("hit", i, {63'b0, hit}, {63'b0, vecs[i].eh});
                check("taken", i, {63'b0, taken}, {63'b0, vecs[i].et});
                check("target", i, target, vecs[i].etgt);
                check("cnt", i, {32'b0, cnt}, {32'b0, vecs[i].ecnt});
            end
            @(posedge clk); #1;
        end

        // Narrow counter saturation followed by reset clearing everything.
        idle_upd(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle_upd(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("small_cnt_reset", 100, {60'b0, s_cnt}, 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            idle_upd(1'b0, 1'b1, 1'b1);
            @(posedge clk); #1;
            if (i == 14) check("small_cnt_15", 101, {60'b0, s_cnt}, 64'd15);
        end
        idle_upd(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("small_cnt_sat", 102, {60'b0, s_cnt}, 64'd15);
        check("big_cnt_20", 103, {32'b0, cnt}, 64'd20);
        upd_valid = 1'b1; upd_pc = PB; upd_taken = 1'b1; upd_target = T2;
        @(posedge clk); #1;
        idle_upd(1'b0, 1'b0, 1'b0);
        lookup_pc = PB;
        @(negedge clk);
        check("small_hit_pre_rst", 104, {63'b0, s_hit}, 64'd1);
        idle_upd(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle_upd(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("small_cnt_after_rst", 105, {60'b0, s_cnt}, 64'd0);
        check("small_hit_after_rst", 106, {63'b0, s_hit}, 64'd0);
        check("big_hit_after_rst", 107, {63'b0, hit}, 64'd0);
        check("small_target_after_rst", 108, s_target, 64'd0);
        check("small_taken_after_rst", 109, {63'b0, s_taken}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
